// File: rtl/mio_bus_responder.sv
// Target side of the multicycle CPU memory/IO handshake: decodes RAM, GPIO and
// counter space, inserts RAM wait states and returns data with a one-cycle ready pulse.
module mio_bus_responder #(
  parameter int RAM_WAIT = 2,
  parameter int RAM_AW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mio_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic [1:0]        state_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RESP    = 2'd2,
    S_WR      = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RG_RAM  = 2'd0,
    RG_GPIO = 2'd1,
    RG_CNT  = 2'd2,
    RG_NONE = 2'd3
  } region_t;

  localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT - 1);

  function automatic region_t decode_region(input logic [3:0] nib);
    region_t r;
    case (nib)
      4'h0:    r = RG_RAM;
      4'hE:    r = RG_GPIO;
      4'hF:    r = RG_CNT;
      default: r = RG_NONE;
    endcase
    return r;
  endfunction

  state_t              state_q, state_d;
  region_t             region_q, region_d;
  region_t             req_region_s;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wait_q, wait_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [15:0]         led_q, led_d;
  logic [31:0]         cnt_q, cnt_d;

  // Address bits that select neither region nor RAM word are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[1:0], addr[27:RAM_AW+2]};

  assign req_region_s = decode_region(addr[31:28]);

  // Next-state, datapath and registered-output decisions.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wait_d   = wait_q;
    rdata_d  = rdata_q;
    led_d    = led_q;
    cnt_d    = cnt_q + 32'd1;
    case (state_q)
      S_IDLE: begin
        if (mem_w) begin
          addr_d   = addr[RAM_AW+1:2];
          wdata_d  = wdata;
          region_d = req_region_s;
          state_d  = S_WR;
        end else if (mem_r) begin
          addr_d   = addr[RAM_AW+1:2];
          region_d = req_region_s;
          if (req_region_s == RG_RAM) begin
            wait_d  = WAIT_INIT;
            state_d = S_RD_WAIT;
          end else begin
            state_d = S_RESP;
            case (req_region_s)
              RG_GPIO: rdata_d = {16'd0, sw_in};
              RG_CNT:  rdata_d = cnt_q;
              default: rdata_d = 32'd0;
            endcase
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (wait_q == 4'd0) begin
          rdata_d = ram_dout;
          state_d = S_RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      S_WR: begin
        state_d = S_IDLE;
        if (region_q == RG_GPIO) begin
          led_d = wdata_q[15:0];
        end else if (region_q == RG_CNT) begin
          cnt_d = wdata_q;
        end else begin
          led_d = led_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Strobes are registered so they are high exactly while in WR/RESP.
    ready_d = (state_d == S_WR) || (state_d == S_RESP);
    we_d    = (state_d == S_WR) && (region_d == RG_RAM);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      region_q <= RG_RAM;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      wait_q   <= 4'd0;
      rdata_q  <= 32'd0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      led_q    <= 16'd0;
      cnt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      led_q    <= led_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata     = rdata_q;
  assign mio_ready = ready_q;
  assign ram_addr  = addr_q;
  assign ram_we    = we_q;
  assign ram_din   = wdata_q;
  assign led_out   = led_q;
  assign state_out = state_q;

endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO bus responder for the multicycle CPU: the target side of the CPU's MemRead/MemWrite/MIO_ready handshake. It decodes each request address into RAM, GPIO or counter space, runs the access with a programmable number of RAM wait states, and returns read data together with a one-cycle `mio_ready` pulse. It sits between the multicycle control/datapath and the block RAM plus board peripherals.

## Interface
- `RAM_WAIT`, default 2: cycles from RAM request sampling to RAM data capture; legal range 1..15.
- `RAM_AW`, default 10: RAM word-address width.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `mem_r`  in  1  CPU read request (level, held until `mio_ready` seen)
- `mem_w`  in  1  CPU write request (level, may be a single cycle)
- `addr`  in  32  CPU byte address
- `wdata`  in  32  CPU write data
- `rdata`  out  32  read data to CPU, valid while `mio_ready`=1
- `mio_ready`  out  1  one-cycle completion pulse
- `ram_addr`  out  RAM_AW  RAM word address, equal to `addr[RAM_AW+1:2]` latched
- `ram_we`  out  1  RAM write strobe
- `ram_din`  out  32  RAM write data
- `ram_dout`  in  32  RAM read data, synchronous RAM, one-cycle latency
- `sw_in`  in  16  board switches
- `led_out`  out  16  LED register
- `state_out`  out  2  current FSM state, for debug display

## Operation
- Address map by `addr[31:28]`: 0x0 RAM; 0xE GPIO (read returns {16'b0, `sw_in`}, write loads `led_out` from `wdata[15:0]`); 0xF counter (read returns the 32-bit free-running counter, write loads it from `wdata`); any other value unmapped (read returns 0, write ignored, still completes).
- FSM states: IDLE=0, RD_WAIT=1, RESP=2, WR=3.
- IDLE: on a clock edge with `mem_w`=1, latch `addr`/`wdata` and go to WR; otherwise with `mem_r`=1, latch `addr` and go to RD_WAIT (RAM) or RESP (GPIO/counter/unmapped). Write has priority when `mem_r` and `mem_w` are both 1.
- WR: `ram_we`=1 only if the latched region is RAM; GPIO/counter registers load on this edge; `mio_ready`=1; next state IDLE.
- RD_WAIT: wait counter loads RAM_WAIT-1 on entry and decrements; at 0, capture `ram_dout` into `rdata` and go to RESP.
- RESP: `mio_ready`=1, `rdata` holds the captured value (GPIO/counter values are captured on the IDLE->RESP edge); next state IDLE unconditionally. A request still high in the following IDLE cycle is treated as a new request.
- The counter increments by 1 every cycle, wrapping 0xFFFFFFFF->0; a counter write in WR overrides the increment for that cycle.
- `ram_addr`/`ram_din` are driven from the latched registers and are stable throughout RD_WAIT/WR.

## Timing
- Reset values: state IDLE, `mio_ready`=0, `rdata`=0, `ram_we`=0, `led_out`=0, counter=0, latched addr/data=0.
- Request sampled at edge T (IDLE). Write: `mio_ready`/`ram_we` high during cycle T+1. RAM read: `mio_ready` high during cycle T+RAM_WAIT+1. Non-RAM read: `mio_ready` high during cycle T+1.
- `mio_ready` and `ram_we` are never high for 2 consecutive cycles; at least one IDLE cycle separates transactions.
- Requests that change or drop while not in IDLE are ignored; the latched transaction completes.
- Reset mid-operation: immediate return to IDLE, no `mio_ready`, and the pending write is discarded if WR has not yet been reached.
- The `rdata` value holds until the next read capture; it is not cleared after RESP.

## Test plan
- Reset then idle 5 cycles -> `mio_ready`=0, `led_out`=0, counter reads 5 or 6 per sampling edge; `state_out`=0.
- Write 0xDEADBEEF to 0x00000010, then read 0x00000010 with RAM_WAIT=2 -> `ram_we` pulse with `ram_addr`=4; read `mio_ready` at T+3 with `rdata`=0xDEADBEEF.
- Write 0x0000A5A5 to 0xE0000000, then read 0xE0000000 with `sw_in`=0x1234 -> `led_out`=0xA5A5 after WR; read returns 0x00001234 at T+1.
- Write 0xFFFFFFFE to 0xF0000000, then read 3 cycles later -> counter wrapped; read returns 0x00000000 or 0x00000001 per exact edge, with the value checked against the model.
- `mem_r`=`mem_w`=1 at 0x00000020 with wdata 7 -> write performed, single `mio_ready`; no read pulse. Unmapped read at 0x50000000 -> `rdata`=0, `mio_ready` at T+1.
- Assert reset during RD_WAIT -> no `mio_ready`, state IDLE, next read completes with normal latency.
